// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-sequencer state encoding, decoder PC-control
// codes and the instruction word width.
package cpu_pkg;

  localparam int INSTR_W = 32;

  localparam logic [1:0] CTRL_PC_SEQ  = 2'd0;
  localparam logic [1:0] CTRL_PC_JUMP = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DRAIN
  } pc_seq_state_t;

endpackage

// File: rtl/pc_redirect_mux.sv
// Combinational redirect selection for the fetch sequencer. Branch redirects
// exist only when PC_SEQ_BRANCH_EN is defined; otherwise only jumps redirect.
module pc_redirect_mux
  import cpu_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [1:0]      ctrl_pc,
  input  logic [31:0]     jump,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_pc,
  input  logic [15:0]     br_offset,
  input  logic            flush,
  input  logic            in_drain,
  output logic            redirect,
  output logic [PC_W-1:0] target
);

  logic jump_req;
  logic qualify;

  assign jump_req = (ctrl_pc == CTRL_PC_JUMP);
  // Redirects seen while flushing or draining come from wrong-path instructions.
  assign qualify  = !flush && !in_drain;

`ifdef PC_SEQ_BRANCH_EN
  logic [PC_W-1:0] br_target;

  assign br_target = br_pc + {{(PC_W-16){br_offset[15]}}, br_offset};
  // The branch is the older instruction, so it wins over a same-cycle jump.
  assign redirect  = qualify && (br_taken || jump_req);
  assign target    = br_taken ? br_target : jump[PC_W-1:0];
`else
  logic unused_branch;

  assign unused_branch = ^{br_taken, br_pc, br_offset};
  assign redirect      = qualify && jump_req;
  assign target        = jump[PC_W-1:0];
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches over imem req/ack and
// issues words to the decoder; optional branch redirect via PC_SEQ_BRANCH_EN.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               RST,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               stall,
  input  logic [1:0]         ctrl_PC,
  input  logic [31:0]        jump,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_pc,
  input  logic [15:0]        br_offset,
  output logic               flush
);

  pc_seq_state_t     state, state_nxt;
  logic [PC_W-1:0]   fetch_pc, fetch_pc_nxt;
  logic [PC_W-1:0]   drain_addr, drain_addr_nxt;
  logic [INSTR_W-1:0] instr_out_nxt;
  logic [PC_W-1:0]   instr_pc_nxt;
  logic              instr_valid_nxt;
  logic              flush_nxt;
  logic              redirect;
  logic [PC_W-1:0]   target;

  pc_redirect_mux #(.PC_W(PC_W)) u_redirect (
    .ctrl_pc   (ctrl_PC),
    .jump      (jump),
    .br_taken  (br_taken),
    .br_pc     (br_pc),
    .br_offset (br_offset),
    .flush     (flush),
    .in_drain  (state == S_DRAIN),
    .redirect  (redirect),
    .target    (target)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (RST) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      drain_addr  <= RESET_PC;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
      flush       <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      drain_addr  <= drain_addr_nxt;
      instr_out   <= instr_out_nxt;
      instr_valid <= instr_valid_nxt;
      instr_pc    <= instr_pc_nxt;
      flush       <= flush_nxt;
    end
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    drain_addr_nxt  = drain_addr;
    instr_out_nxt   = instr_out;
    instr_pc_nxt    = instr_pc;
    instr_valid_nxt = 1'b0;
    flush_nxt       = redirect;

    unique case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
        if (redirect) fetch_pc_nxt = target;
      end
      S_FETCH: begin
        if (redirect) begin
          fetch_pc_nxt = target;
          // An outstanding request is never withdrawn: drain it at the old address.
          if (!imem_ack) begin
            state_nxt      = S_DRAIN;
            drain_addr_nxt = fetch_pc;
          end
        end else if (imem_ack) begin
          state_nxt       = S_ISSUE;
          instr_out_nxt   = imem_rdata;
          instr_pc_nxt    = fetch_pc;
          instr_valid_nxt = 1'b1;
        end
      end
      S_ISSUE: begin
        if (redirect) begin
          fetch_pc_nxt = target;
          state_nxt    = S_FETCH;
        end else if (!stall) begin
          fetch_pc_nxt = fetch_pc + PC_W'(1);
          state_nxt    = S_FETCH;
        end else begin
          instr_valid_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        if (imem_ack) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state == S_FETCH) || (state == S_DRAIN);
    imem_addr = (state == S_DRAIN) ? drain_addr : fetch_pc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a directed vector table plus a
// zero-wait-memory sequence; branch expectations follow PC_SEQ_BRANCH_EN.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        RST;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        stall;
  logic [1:0]  ctrl_PC;
  logic [31:0] jump;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [15:0] br_offset;
  logic        flush;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(32), .RESET_PC(32'h10)) dut (
    .clk         (clk),
    .RST         (RST),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_pc    (instr_pc),
    .stall       (stall),
    .ctrl_PC     (ctrl_PC),
    .jump        (jump),
    .br_taken    (br_taken),
    .br_pc       (br_pc),
    .br_offset   (br_offset),
    .flush       (flush)
  );

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic [1:0]  ctrl;
    logic [31:0] jump;
    logic        brt;
    logic [31:0] brpc;
    logic [15:0] broff;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        flush;
  } vec_t;

`ifdef PC_SEQ_BRANCH_EN
  localparam logic [31:0] TGT_BJ  = 32'h1E;   // 0x20 + (-2)
  localparam logic [31:0] TGT_BR  = 32'h104;  // 0x100 + 4
  localparam logic        FLUSH_BR = 1'b1;
`else
  localparam logic [31:0] TGT_BJ  = 32'h80;   // jump only
  localparam logic [31:0] TGT_BR  = 32'h81;   // branch ignored, sequential
  localparam logic        FLUSH_BR = 1'b0;
`endif

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic ack, input logic [31:0] rdata,
                              input logic stl, input logic [1:0] ctrl, input logic [31:0] jmp,
                              input logic brt, input logic [31:0] brpc, input logic [15:0] broff,
                              input logic req, input logic [31:0] addr, input logic valid,
                              input logic [31:0] instr, input logic [31:0] ipc, input logic fl);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.stall = stl; v.ctrl = ctrl; v.jump = jmp;
    v.brt = brt; v.brpc = brpc; v.broff = broff; v.req = req; v.addr = addr; v.valid = valid;
    v.instr = instr; v.ipc = ipc; v.flush = fl;
    return v;
  endfunction

  initial begin
    int cycles;
    logic [31:0] exp_pc;

    RST = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    ctrl_PC = 2'd0; jump = '0; br_taken = 1'b0; br_pc = '0; br_offset = '0;

    //                rst ack rdata          stl ctrl jump          brt brpc      broff     req addr           val instr          ipc            fl
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,   16'h0,    0, 32'h10,       0, 32'h0,         32'h0,         0)); // 0 reset
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,   16'h0,    1, 32'h10,       0, 32'h0,         32'h0,         0)); // 1 first req
    vecs.push_back(mk(0, 1, 32'hA0000010,  0, 0, 32'h0,         0, 32'h0,   16'h0,    0, 32'h10,       1, 32'hA0000010,  32'h10,        0)); // 2 issue
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,   16'h0,    1, 32'h11,       0, 32'hA0000010,  32'h10,        0)); // 3
    vecs.push_back(mk(0, 1, 32'hA0000011,  0, 0, 32'h0,         0, 32'h0,   16'h0,    0, 32'h11,       1, 32'hA0000011,  32'h11,        0)); // 4
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   16'h0,    0, 32'h11,       1, 32'hA0000011,  32'h11,        0)); // 5 stall
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   16'h0,    0, 32'h11,       1, 32'hA0000011,  32'h11,        0)); // 6 stall
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   16'h0,    0, 32'h11,       1, 32'hA0000011,  32'h11,        0)); // 7 stall
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,   16'h0,    1, 32'h12,       0, 32'hA0000011,  32'h11,        0)); // 8 released
    vecs.push_back(mk(0, 1, 32'hA0000012,  0, 0, 32'h0,         0, 32'h0,   16'h0,    0, 32'h12,       1, 32'hA0000012,  32'h12,        0)); // 9
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,   16'h0,    1, 32'h13,       0, 32'hA0000012,  32'h12,        0)); // 10
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h40,        0, 32'h0,   16'h0,    1, 32'h13,       0, 32'hA0000012,  32'h12,        1)); // 11 jump -> drain
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h99,        0, 32'h0,   16'h0,    1, 32'h13,       0, 32'hA0000012,  32'h12,        0)); // 12 ignored
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,   16'h0,    1, 32'h13,       0, 32'hA0000012,  32'h12,        0)); // 13 drain
    vecs.push_back(mk(0, 1, 32'hDEADBEEF,  0, 0, 32'h0,         0, 32'h0,   16'h0,    1, 32'h40,       0, 32'hA0000012,  32'h12,        0)); // 14 discard
    vecs.push_back(mk(0, 1, 32'hA0000040,  0, 0, 32'h0,         0, 32'h0,   16'h0,    0, 32'h40,       1, 32'hA0000040,  32'h40,        0)); // 15
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h20,        0, 32'h0,   16'h0,    1, 32'h20,       0, 32'hA0000040,  32'h40,        1)); // 16 squash in issue
    vecs.push_back(mk(0, 1, 32'hA0000020,  0, 1, 32'h77,        0, 32'h0,   16'h0,    0, 32'h20,       1, 32'hA0000020,  32'h20,        0)); // 17 flush ignores jump
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h80,        1, 32'h20,  16'hFFFE, 1, TGT_BJ,       0, 32'hA0000020,  32'h20,        1)); // 18 br+jump
    vecs.push_back(mk(0, 1, 32'h12345678,  0, 0, 32'h0,         0, 32'h0,   16'h0,    0, TGT_BJ,       1, 32'h12345678,  TGT_BJ,        0)); // 19
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h100, 16'h0004, 1, TGT_BR,       0, 32'h12345678,  TGT_BJ,        FLUSH_BR)); // 20 branch only
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,   16'h0,    1, TGT_BR,       0, 32'h12345678,  TGT_BJ,        0)); // 21
    vecs.push_back(mk(0, 1, 32'h00000BAD,  0, 1, 32'hFFFFFFFF,  0, 32'h0,   16'h0,    1, 32'hFFFFFFFF, 0, 32'h12345678,  TGT_BJ,        1)); // 22 jump on ack
    vecs.push_back(mk(0, 1, 32'hCAFEF00D,  0, 0, 32'h0,         0, 32'h0,   16'h0,    0, 32'hFFFFFFFF, 1, 32'hCAFEF00D,  32'hFFFFFFFF,  0)); // 23
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,   16'h0,    1, 32'h0,        0, 32'hCAFEF00D,  32'hFFFFFFFF,  0)); // 24 wrap
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h55,        0, 32'h0,   16'h0,    1, 32'h0,        0, 32'hCAFEF00D,  32'hFFFFFFFF,  1)); // 25 drain
    vecs.push_back(mk(1, 0, 32'h0,         0, 1, 32'h66,        0, 32'h0,   16'h0,    0, 32'h10,       0, 32'h0,         32'h0,         0)); // 26 reset in drain
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,   16'h0,    1, 32'h10,       0, 32'h0,         32'h0,         0)); // 27
    vecs.push_back(mk(0, 1, 32'h0BADF00D,  0, 0, 32'h0,         0, 32'h0,   16'h0,    0, 32'h10,       1, 32'h0BADF00D,  32'h10,        0)); // 28
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,   16'h0,    0, 32'h10,       0, 32'h0,         32'h0,         0)); // 29 reset
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h30,        0, 32'h0,   16'h0,    1, 32'h30,       0, 32'h0,         32'h0,         1)); // 30 idle jump

    foreach (vecs[i]) begin
      @(negedge clk);
      RST = vecs[i].rst; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
      stall = vecs[i].stall; ctrl_PC = vecs[i].ctrl; jump = vecs[i].jump;
      br_taken = vecs[i].brt; br_pc = vecs[i].brpc; br_offset = vecs[i].broff;
      @(posedge clk);
      #1;
      check($sformatf("v%0d req", i),   32'(imem_req),    32'(vecs[i].req));
      check($sformatf("v%0d addr", i),  imem_addr,        vecs[i].addr);
      check($sformatf("v%0d valid", i), 32'(instr_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d instr", i), instr_out,        vecs[i].instr);
      check($sformatf("v%0d ipc", i),   instr_pc,         vecs[i].ipc);
      check($sformatf("v%0d flush", i), 32'(flush),       32'(vecs[i].flush));
    end

    // Fresh reset, then a zero-wait memory: req one edge after RST falls,
    // one instruction every two cycles.
    @(negedge clk);
    RST = 1'b1; imem_ack = 1'b0; ctrl_PC = 2'd0; br_taken = 1'b0; stall = 1'b0;
    @(negedge clk);
    RST = 1'b0;
    cycles = 0;
    while (!imem_req && cycles < 10) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("first req edges", 32'(cycles), 32'd1);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      imem_ack   = imem_req;
      imem_rdata = ~imem_addr;
      @(posedge clk);
      #1;
      check($sformatf("zw%0d valid", i), 32'(instr_valid), 32'((i % 2) == 0));
      if ((i % 2) == 0) begin
        exp_pc = 32'h10 + 32'(i / 2);
        check($sformatf("zw%0d ipc", i),   instr_pc,  exp_pc);
        check($sformatf("zw%0d instr", i), instr_out, ~exp_pc);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction fetch sequencer for the 32-bit CPU. Owns the program counter, fetches one instruction word at a time from instruction memory over a req/ack handshake, and presents it to the decoder's `INSTR_IN` with a valid/stall handshake. It applies redirects from jumps (decoder `ctrl_PC`/`jump`) and taken branches (execute-stage BEQ/BNE compare), squashing wrong-path fetches and pulsing `flush` downstream.

## Interface
- `PC_W`, 32, PC and address width
- `RESET_PC`, 32'h0, first fetch address after reset
- `clk`  in  1  clock
- `RST`  in  1  reset; synchronous, active-high
- `imem_req`  out  1  fetch request, held until `imem_ack`
- `imem_addr`  out  PC_W  fetch address (instruction index)
- `imem_ack`  in  1  request accepted; `imem_rdata` valid this cycle
- `imem_rdata`  in  32  fetched instruction word
- `instr_out`  out  32  instruction to decoder `INSTR_IN`
- `instr_valid`  out  1  `instr_out` is valid
- `instr_pc`  out  PC_W  PC of `instr_out`
- `stall`  in  1  downstream cannot consume this cycle
- `ctrl_PC`  in  2  decoder PC control; 2'd1 = jump
- `jump`  in  32  jump target (PC_W LSBs used)
- `br_taken`  in  1  execute stage: BEQ/BNE taken
- `br_pc`  in  PC_W  PC of the branch instruction
- `br_offset`  in  16  branch offset (decoder `const[15:0]`), signed
- `flush`  out  1  one-cycle pulse: squash in-flight decode/execute

## Operation
- States: IDLE, FETCH, ISSUE, DRAIN. `fetch_pc` is the internal next-fetch address.
- IDLE: entered on reset; unconditionally goes to FETCH the next cycle.
- FETCH: `imem_req`=1, `imem_addr`=`fetch_pc`. On `imem_ack`, capture `imem_rdata` into `instr_out`, `fetch_pc` into `instr_pc`, then go to ISSUE.
- ISSUE: `instr_valid`=1. With `stall`=0 the word is consumed: `fetch_pc`+=1 (wraps 2^PC_W-1 → 0), go to FETCH. With `stall`=1: hold all outputs.
- Redirect sources: jump when `ctrl_PC`==2'd1, target=`jump[PC_W-1:0]`. Branch when `br_taken`=1, target=`br_pc`+sign-extended `br_offset`, modulo 2^PC_W.
- If both sources fire in the same cycle, the branch wins because it is the older instruction.
- Accepted redirect: `fetch_pc`←target; `flush`=1 for the next cycle.
  - In FETCH with `imem_ack`=0: go to DRAIN. A request is never withdrawn.
  - In FETCH with `imem_ack`=1: discard data, stay in FETCH at target.
  - In ISSUE: drop `instr_valid` and go to FETCH. The held word is squashed even if `stall`=0 that cycle.
  - In IDLE: go to FETCH at target.
- DRAIN: `imem_req`=1 at the old address until `imem_ack`. Discard the data, then go to FETCH at target.
- Redirects are ignored while in DRAIN and in any cycle where `flush`=1 (they are wrong-path).
- `stall` has no effect outside ISSUE.

## Timing
- Reset (synchronous, `RST`=1 at posedge) overrides all other inputs:
  - state=IDLE, `fetch_pc`=`RESET_PC`.
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_out`=0, `instr_valid`=0, `instr_pc`=0, `flush`=0.
- Reset mid-handshake abandons any outstanding request. Memory must accept an `imem_req` deassertion caused by reset.
- First `imem_req` is in the 2nd cycle after `RST` falls (one cycle in IDLE).
- Fetch latency: `instr_valid` rises the cycle after `imem_ack`.
- Peak throughput with zero-wait memory: one instruction per 2 cycles.
- Redirect to first target request: 1 cycle (no outstanding request), or the ack cycle + 1 (DRAIN).
- All outputs are registered except `imem_req`/`imem_addr`, which decode from registered state and `fetch_pc` only.

## Configuration
- `PC_SEQ_BRANCH_EN` defined:
  - branch redirects are active as described.
- Not defined:
  - `br_taken`, `br_pc` and `br_offset` are ignored (ports remain).
  - Only jumps redirect; branch adder logic is absent.

## Structure
- Shared package `cpu_pkg`:
  - state enum `pc_seq_state_t`.
  - `CTRL_PC_SEQ`=2'd0, `CTRL_PC_JUMP`=2'd1.
  - `INSTR_W`=32.
- One natural sub-module: `pc_redirect_mux`. It is combinational: it takes the jump/branch inputs and `flush`/DRAIN qualifiers, and outputs `redirect` and `target`.

## Test plan
- Reset with `RESET_PC`=0x10, zero-wait memory, `stall`=0 → fetch addresses 0x10, 0x11, 0x12 on alternating cycles; `instr_pc` matches each word.
- `stall`=1 for 3 cycles in ISSUE → `instr_out`/`instr_pc` stable and no `imem_req` until the cycle after `stall` falls.
- `ctrl_PC`=1 with `jump`=0x40 while FETCH is waiting on ack (ack delayed 3 cycles) → DRAIN holds the old address until ack, that data is discarded, next request is 0x40, one `flush` pulse.
- Branch (`br_pc`=0x20, `br_offset`=0xFFFE) and jump (0x80) in the same cycle → next fetch 0x1E. With the macro undefined, next fetch is 0x80.
- `fetch_pc`=0xFFFFFFFF consumed → next fetch 0x00000000.
- `RST` asserted while DRAIN has an outstanding request → next cycle all outputs at reset values; refetch starts at `RESET_PC`.
